// File: rtl/qspi_slave_if.sv
`timescale 1ns/1ps
// qspi_slave_if
// SPI / quad-SPI slave front-end running entirely in the clk domain.
// The master pins are oversampled through a synchronizer. MOSI is
// deserialized into bytes on a valid/ready stream. Response bytes are
// serialized onto MISO, and MISO advances on each SCLK falling edge.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   spi_sclk          SPI clock from master (mode 0, idle low)
//   spi_cs_n          chip select, active low
//   spi_mosi[3:0]     master->slave lanes
//   spi_miso[3:0]     slave->master lanes
//   spi_miso_oe[3:0]  per-lane output enable
//   lane_mode[1:0]    00 = 1 lane, 01 = 2 lanes, 1x = 4 lanes (latched at frame start)
//   rx_data/rx_valid/rx_ready   received byte stream
//   tx_data/tx_valid/tx_ready   response byte source (tx_ready pulses on take)
//   busy              frame in progress
//   rx_ovf, tx_udf, frame_err   sticky error flags, cleared by clr_flags
module qspi_slave_if #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] TX_IDLE     = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic [3:0] spi_mosi,
    output logic [3:0] spi_miso,
    output logic [3:0] spi_miso_oe,
    input  logic [1:0] lane_mode,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       rx_ovf,
    output logic       tx_udf,
    output logic       frame_err,
    input  logic       clr_flags
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // Lane select encoding: 0 = 1 lane, 1 = 2 lanes, 2 = 4 lanes
    function automatic logic [3:0] lane_group(input logic [7:0] b, input logic [1:0] ls);
        case (ls)
            2'd0:    lane_group = {3'b000, b[0]};
            2'd1:    lane_group = {2'b00, b[1:0]};
            default: lane_group = b[3:0];
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] ls);
        case (ls)
            2'd0:    lane_mask = 4'b0001;
            2'd1:    lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Synchronizers
    logic [SYNC_STAGES-1:0] sclk_pipe;
    logic [SYNC_STAGES-1:0] cs_pipe;
    logic [SYNC_STAGES-1:0] flush_sr;
    logic [3:0]             mosi_pipe [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_pipe <= '0;
            cs_pipe   <= '1;
            flush_sr  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) mosi_pipe[i] <= 4'h0;
        end else begin
            sclk_pipe    <= {sclk_pipe[SYNC_STAGES-2:0], spi_sclk};
            cs_pipe      <= {cs_pipe[SYNC_STAGES-2:0], spi_cs_n};
            flush_sr     <= {flush_sr[SYNC_STAGES-2:0], 1'b1};
            mosi_pipe[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) mosi_pipe[i] <= mosi_pipe[i-1];
        end
    end

    logic       sclk_s, cs_s;
    logic [3:0] mosi_s;
    assign sclk_s = sclk_pipe[SYNC_STAGES-1];
    assign cs_s   = cs_pipe[SYNC_STAGES-1];
    assign mosi_s = mosi_pipe[SYNC_STAGES-1];

    // Edge detection. A frame start is only accepted once CS_n has been
    // seen high after the synchronizer has flushed its reset values, so a
    // frame already in progress when reset releases is ignored.
    logic sclk_d, cs_d, armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
            armed  <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
            if (flush_sr[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
        end
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = armed & cs_d & ~cs_s;
    assign cs_rise   = cs_s & ~cs_d;

    // Datapath state
    state_t     state;
    logic [1:0] lsel;
    logic [2:0] beat_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;

    logic [1:0] lsel_in;
    logic [7:0] tx_byte;
    logic [7:0] rx_next;
    logic [7:0] tx_next;
    logic [2:0] beat_max;

    always_comb begin
        lsel_in  = (lane_mode == 2'b00) ? 2'd0 : (lane_mode == 2'b01) ? 2'd1 : 2'd2;
        tx_byte  = tx_valid ? tx_data : TX_IDLE;
        // New group enters at the top and the register shifts right, so
        // after B beats the first (least significant) group sits in bit 0.
        rx_next  = rx_shift;
        tx_next  = tx_shift;
        beat_max = 3'd1;
        case (lsel)
            2'd0: begin
                rx_next  = {mosi_s[0], rx_shift[7:1]};
                tx_next  = {1'b0, tx_shift[7:1]};
                beat_max = 3'd7;
            end
            2'd1: begin
                rx_next  = {mosi_s[1:0], rx_shift[7:2]};
                tx_next  = {2'b00, tx_shift[7:2]};
                beat_max = 3'd3;
            end
            default: begin
                rx_next  = {mosi_s, rx_shift[7:4]};
                tx_next  = {4'h0, tx_shift[7:4]};
                beat_max = 3'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lsel        <= 2'd0;
            beat_cnt    <= 3'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
            spi_miso    <= 4'h0;
            spi_miso_oe <= 4'h0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b0;
            busy        <= 1'b0;
            rx_ovf      <= 1'b0;
            tx_udf      <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            // Clears come first so that a set later in this block wins.
            if (clr_flags) begin
                rx_ovf    <= 1'b0;
                tx_udf    <= 1'b0;
                frame_err <= 1'b0;
            end
            if (rx_valid && rx_ready) rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        lsel        <= lsel_in;
                        beat_cnt    <= 3'd0;
                        rx_shift    <= 8'h00;
                        tx_shift    <= tx_byte;
                        tx_ready    <= tx_valid;
                        if (!tx_valid) tx_udf <= 1'b1;
                        spi_miso    <= lane_group(tx_byte, lsel_in);
                        spi_miso_oe <= lane_mask(lsel_in);
                        busy        <= 1'b1;
                        state       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        if (beat_cnt != 3'd0) frame_err <= 1'b1;
                        spi_miso    <= 4'h0;
                        spi_miso_oe <= 4'h0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next;
                        if (beat_cnt == beat_max) begin
                            beat_cnt <= 3'd0;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                            end else begin
                                rx_ovf <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 3'd1;
                        end
                    end else if (sclk_fall) begin
                        if (beat_cnt == 3'd0) begin
                            // Byte boundary just crossed: start the next response byte.
                            tx_shift <= tx_byte;
                            tx_ready <= tx_valid;
                            if (!tx_valid) tx_udf <= 1'b1;
                            spi_miso <= lane_group(tx_byte, lsel);
                        end else begin
                            tx_shift <= tx_next;
                            spi_miso <= lane_group(tx_next, lsel);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_slave_if.sv
`timescale 1ns/1ps
// Testbench for qspi_slave_if: directed frames from a bit-banged SPI master,
// with received bytes checked by a scoreboard monitor.
module tb_qspi_slave_if;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic [3:0] mosi = 4'h0;
    logic [3:0] miso;
    logic [3:0] oe;
    logic [1:0] lane_mode = 2'b10;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       rx_ovf;
    logic       tx_udf;
    logic       frame_err;
    logic       clr_flags = 1'b0;

    int errors = 0;
    int checks = 0;
    int tx_pulses = 0;
    logic [7:0] exp_q[$];

    qspi_slave_if #(.SYNC_STAGES(2), .TX_IDLE(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .spi_miso(miso), .spi_miso_oe(oe), .lane_mode(lane_mode),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .rx_ovf(rx_ovf), .tx_udf(tx_udf), .frame_err(frame_err),
        .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every accepted rx byte is popped and compared.
    always @(negedge clk) begin
        if (tx_ready) tx_pulses++;
        if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %02h expected none", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("rx_byte", {24'h0, rx_data}, {24'h0, e});
                $display("rx byte %02h (expected %02h)", rx_data, e);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCLK beat: drive mosi, rise, then sample miso at the falling edge.
    task automatic do_beat(input logic [3:0] m, input bit end_cs, output logic [3:0] s);
        mosi = m;
        wait_clk(8);
        sclk = 1'b1;
        wait_clk(8);
        s = miso;
        sclk = 1'b0;
        if (end_cs) cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic send_frame(input logic [1:0] mode, input int n,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input bit push_rx, input bit chk_miso,
                              input logic [7:0] exp_miso, input logic [3:0] exp_oe);
        logic [7:0] bytes [3];
        logic [7:0] got;
        logic [3:0] s, msk, grp;
        int L, B;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        lane_mode = mode;
        L = (mode == 2'b00) ? 1 : (mode == 2'b01) ? 2 : 4;
        B = 8 / L;
        msk = (mode == 2'b00) ? 4'b0001 : (mode == 2'b01) ? 4'b0011 : 4'b1111;
        if (push_rx) for (int i = 0; i < n; i++) exp_q.push_back(bytes[i]);
        cs_n = 1'b0;
        wait_clk(8);
        for (int i = 0; i < n; i++) begin
            got = 8'h00;
            for (int k = 0; k < B; k++) begin
                grp = 4'(bytes[i] >> (k * L)) & msk;
                do_beat(grp, (i == n - 1) && (k == B - 1), s);
                got = got | 8'({4'h0, s & msk} << (k * L));
                if (k == 0) chk("miso_oe", {28'h0, oe}, {28'h0, exp_oe});
            end
            if (chk_miso) begin
                chk("miso_byte", {24'h0, got}, {24'h0, exp_miso});
                $display("tx byte %0d sampled %02h (expected %02h)", i, got, exp_miso);
            end
        end
        wait_clk(8);
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        wait_clk(1);
        clr_flags = 1'b0;
        wait_clk(1);
    endtask

    initial begin
        logic [3:0] s;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(6);
        chk("reset_outputs", {miso, oe, rx_data, rx_valid, tx_ready, busy, rx_ovf, tx_udf, frame_err},
            32'h0);

        // 4 lanes, two bytes, response A5 each byte
        tx_valid = 1'b1; tx_data = 8'hA5; tx_pulses = 0;
        send_frame(2'b10, 2, 8'h3C, 8'h81, 8'h00, 1'b1, 1'b1, 8'hA5, 4'b1111);
        chk("tx_ready_pulses", tx_pulses, 2);
        chk("flags_4lane", {29'h0, rx_ovf, tx_udf, frame_err}, 32'h0);
        chk("idle_after_frame", {27'h0, busy, oe}, 32'h0);

        // 1 lane, two bytes
        tx_data = 8'h96;
        send_frame(2'b00, 2, 8'hC3, 8'h5A, 8'h00, 1'b1, 1'b1, 8'h96, 4'b0001);
        chk("flags_1lane", {29'h0, rx_ovf, tx_udf, frame_err}, 32'h0);

        // 2 lanes, no tx data: idle byte sent, underflow flagged
        tx_valid = 1'b0;
        send_frame(2'b01, 2, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1, 8'hFF, 4'b0011);
        chk("tx_udf_set", {31'h0, tx_udf}, 32'h1);
        pulse_clr();
        chk("tx_udf_cleared", {31'h0, tx_udf}, 32'h0);

        // Consumer stalled: three bytes, first held, overflow flagged
        tx_valid = 1'b1; tx_data = 8'h00; rx_ready = 1'b0;
        send_frame(2'b10, 3, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 8'h00, 4'b1111);
        chk("ovf_rx_data", {24'h0, rx_data}, 32'h11);
        chk("ovf_rx_valid", {31'h0, rx_valid}, 32'h1);
        chk("ovf_flag", {31'h0, rx_ovf}, 32'h1);
        exp_q.push_back(8'h11);
        rx_ready = 1'b1;
        wait_clk(3);
        chk("ovf_drained", {31'h0, rx_valid}, 32'h0);
        pulse_clr();
        chk("ovf_cleared", {31'h0, rx_ovf}, 32'h0);

        // Frame aborted after one beat
        lane_mode = 2'b10;
        cs_n = 1'b0;
        wait_clk(8);
        do_beat(4'h5, 1'b0, s);
        cs_n = 1'b1;
        wait_clk(4);
        chk("abort_state", {28'h0, frame_err, busy, rx_valid, |oe}, 32'h8);
        chk("abort_oe", {28'h0, oe}, 32'h0);
        wait_clk(8);
        pulse_clr();

        // Reset mid-byte: rest of that frame is ignored
        cs_n = 1'b0;
        wait_clk(8);
        do_beat(4'h3, 1'b0, s);
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        chk("reset_mid_frame", {miso, oe, rx_data, rx_valid, tx_ready, busy, rx_ovf, tx_udf, frame_err},
            32'h0);
        do_beat(4'hA, 1'b0, s);
        do_beat(4'h1, 1'b0, s);
        do_beat(4'h2, 1'b1, s);
        wait_clk(8);
        chk("ignored_frame", {miso, oe, rx_data, rx_valid, tx_ready, busy, rx_ovf, tx_udf, frame_err},
            32'h0);

        // Next frame works normally
        tx_data = 8'h5C;
        send_frame(2'b10, 1, 8'h7E, 8'h00, 8'h00, 1'b1, 1'b1, 8'h5C, 4'b1111);
        wait_clk(4);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
